ntt_bfly_pipe: RTL and testbench
================================

# ntt_bfly_pipe

- Parametrised, lane-parallel modular butterfly for the NTT kernel. Replaces the fixed-latency pass-through butterfly.
- Each accepted beat carries LANES independent coefficient pairs and LANES twiddles.
- Computes Cooley-Tukey or Gentleman-Sande butterflies mod Q, or bypasses them.
- Output appears LATENCY cycles later and honours downstream backpressure through a global pipeline stall. Sits between the coefficient-memory read port and the write-back path.

## Interface
Parameters:
- LANES, 4, number of parallel butterflies per beat (>=1)
- W, 32, bits per coefficient lane
- Q, 32'd8380417, modulus; Q < 2^(W-1), Q odd, Q >= 3
- LATENCY, 22, cycles from acceptance to o_vld with no stall (>=3)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  8  per-beat operation select, sampled with the beat
- i_vld  in  1  input beat valid
- i_rdy  out  1  input beat accepted when i_vld && i_rdy
- ai, bi, gm  in  LANES*W  operand a, operand b, twiddle; lane k at [k*W +: W]
- o_vld  out  1  output beat valid
- o_rdy  in  1  output beat consumed when o_vld && o_rdy
- ao, bo  out  LANES*W  results; lane k at [k*W +: W]

## Operation
- mode[1]=1: bypass. ao=ai, bo=bi unchanged; the pipeline latency still applies.
- mode[1]=0, mode[0]=0: CT butterfly. t=(b*w) mod Q; a'=(a+t) mod Q; b'=(a-t+Q) mod Q.
- mode[1]=0, mode[0]=1: GS butterfly. a'=(a+b) mod Q; b'=((a-b+Q) mod Q * w) mod Q.
- mode[7:2] are reserved and ignored.
- Inputs a, b, w are required to be < Q. Outputs are only defined for reduced inputs, and are always < Q.
- Intermediate widths:
  - sums/differences: W+1 bits
  - products: 2W bits
  - no truncation before reduction
- Lanes are fully independent and all use the same mode.
- Pipeline: LATENCY stages. Each stage holds a valid bit, the mode, and the partial lane data.
- Global stall: stall = vld[LATENCY-1] && !o_rdy. While stall is high, no stage register changes.
- i_rdy = !stall. This is combinational from o_rdy and the last-stage valid.
- When not stalled:
  - stage 0 loads the beat if i_vld, else clears its valid
  - every other stage shifts by one
- Internal split of arithmetic across stages is free. It must total exactly LATENCY register stages on every path, bypass included.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.

## Timing
- Reset values: o_vld=0, i_rdy=1 (all valid bits clear), ao=0, bo=0, every stage valid=0.
- Latency: a beat accepted at edge n drives o_vld=1 after edge n+LATENCY-1, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput: one beat per cycle when o_rdy=1 continuously.
- o_vld, ao and bo hold stable while o_vld && !o_rdy.
- o_rdy low with o_vld low does not stall; bubbles are squeezed only at the output.
- Simultaneous accept and consume in the same cycle is legal and keeps full rate.
- rst asserted mid-operation: all in-flight beats are discarded. Next cycle o_vld=0 and i_rdy=1. A beat presented in the rst cycle is not accepted.
- Twiddle and mode are sampled only at acceptance. Later changes on gm/mode do not affect in-flight beats.

## Configuration
- BFLY_CNT_EN defined:
  - adds output port beat_cnt (out, 32): count of output handshakes (o_vld && o_rdy)
  - wraps 2^32-1 -> 0
  - reset to 0 by rst
  - updates the cycle after the handshake
- BFLY_CNT_EN not defined: port and counter absent. Datapath behaviour is identical.

## Test plan
- CT, lane 0 a=5, b=3, w=2, Q=8380417 -> ao lane0=11, bo lane0=8380416, o_vld exactly LATENCY cycles after accept.
- GS with a=5, b=3, w=2 -> ao=8, bo=4. Wrap case CT with a=8380416, b=1, w=1 -> ao=0, bo=8380415.
- Bypass, mode=8'h02, ai=bi=gm=all-ones pattern -> ao/bo equal inputs. Same latency as arithmetic modes.
- Stream 40 beats with o_rdy toggling on a 3-low/2-high pattern -> i_rdy=0 exactly while stalled, outputs held stable during stall, all 40 results in order and correct.
- Assert rst for one cycle with 10 beats in flight -> o_vld=0 next cycle, none of the 10 emerge, and a fresh beat afterwards completes at nominal latency.
- With BFLY_CNT_EN defined: 5 handshakes -> beat_cnt=5. Preload counter near 2^32-1 via force -> wraps to 0.

Source files
------------

// File: rtl/ntt_bfly_pipe.sv
// Lane-parallel modular CT/GS butterfly with a stall-able LATENCY-stage pipeline.
// Optional `BFLY_CNT_EN adds a 32-bit output-handshake counter port beat_cnt.
module ntt_bfly_pipe #(
    parameter int         LANES   = 4,
    parameter int         W       = 32,
    parameter logic [W-1:0] Q     = 32'd8380417,
    parameter int         LATENCY = 22
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           mode,
    input  logic                 i_vld,
    output logic                 i_rdy,
    input  logic [LANES*W-1:0]   ai,
    input  logic [LANES*W-1:0]   bi,
    input  logic [LANES*W-1:0]   gm,
    output logic                 o_vld,
    input  logic                 o_rdy,
    output logic [LANES*W-1:0]   ao,
    output logic [LANES*W-1:0]   bo
`ifdef BFLY_CNT_EN
    ,
    output logic [31:0]          beat_cnt
`endif
);

    localparam int DW = LANES * W;

    logic [LATENCY-1:0] vld;
    logic [1:0]         md  [LATENCY];
    logic [DW-1:0]      a_q [LATENCY];
    logic [DW-1:0]      b_q [LATENCY];
    logic [DW-1:0]      a_d [LATENCY];
    logic [DW-1:0]      b_d [LATENCY];
    logic [DW-1:0]      w0_q, w1_q;
    logic               stall;
    logic               unused_bits;

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, Q} - {1'b0, y};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return W'(p % {{W{1'b0}}, Q});
    endfunction

    assign stall       = vld[LATENCY-1] && !o_rdy;
    assign i_rdy       = !stall;
    assign o_vld       = vld[LATENCY-1];
    assign ao          = a_q[LATENCY-1];
    assign bo          = b_q[LATENCY-1];
    assign unused_bits = ^{mode[7:2], md[LATENCY-1]};

    // Stage 1 does the GS pre-add/sub, stage 2 the multiply and CT post-add/sub;
    // later stages are pure delay. Bypass beats pass through every stage untouched.
    always_comb begin
        logic [W-1:0] t;
        t      = '0;
        a_d[0] = ai;
        b_d[0] = bi;
        for (int s = 1; s < LATENCY; s++) begin
            a_d[s] = a_q[s-1];
            b_d[s] = b_q[s-1];
        end
        for (int k = 0; k < LANES; k++) begin
            if (!md[0][1] && md[0][0]) begin
                a_d[1][k*W +: W] = add_mod(a_q[0][k*W +: W], b_q[0][k*W +: W]);
                b_d[1][k*W +: W] = sub_mod(a_q[0][k*W +: W], b_q[0][k*W +: W]);
            end
            if (!md[1][1]) begin
                t = mul_mod(b_q[1][k*W +: W], w1_q[k*W +: W]);
                if (md[1][0]) begin
                    b_d[2][k*W +: W] = t;
                end else begin
                    a_d[2][k*W +: W] = add_mod(a_q[1][k*W +: W], t);
                    b_d[2][k*W +: W] = sub_mod(a_q[1][k*W +: W], t);
                end
            end
        end
    end

    // NOTE: only the valid bits and the visible output stage are reset; inner
    // data registers are qualified by their valid bit and need no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld            <= '0;
            a_q[LATENCY-1] <= '0;
            b_q[LATENCY-1] <= '0;
        end else if (!stall) begin
            vld   <= {vld[LATENCY-2:0], i_vld};
            md[0] <= mode[1:0];
            w0_q  <= gm;
            w1_q  <= w0_q;
            for (int s = 1; s < LATENCY; s++) md[s] <= md[s-1];
            for (int s = 0; s < LATENCY; s++) begin
                a_q[s] <= a_d[s];
                b_q[s] <= b_d[s];
            end
        end
    end

`ifdef BFLY_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) beat_cnt <= '0;
        else if (o_vld && o_rdy) beat_cnt <= beat_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ntt_bfly_pipe.sv
// Directed self-checking bench for ntt_bfly_pipe (default parameters).
// Counter checks are compiled in only when BFLY_CNT_EN is defined.
module tb_ntt_bfly_pipe;

    localparam int           LANES = 4;
    localparam int           W     = 32;
    localparam logic [W-1:0] Q     = 32'd8380417;
    localparam int           L     = 22;
    localparam int           DW    = LANES * W;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    logic          clk, rst, i_vld, i_rdy, o_vld, o_rdy;
    logic [7:0]    mode;
    logic [DW-1:0] ai, bi, gm, ao, bo;
`ifdef BFLY_CNT_EN
    logic [31:0]   beat_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    ntt_bfly_pipe #(.LANES(LANES), .W(W), .Q(Q), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .mode(mode), .i_vld(i_vld), .i_rdy(i_rdy),
        .ai(ai), .bi(bi), .gm(gm), .o_vld(o_vld), .o_rdy(o_rdy),
        .ao(ao), .bo(bo)
`ifdef BFLY_CNT_EN
        , .beat_cnt(beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model in plain 64-bit modular arithmetic.
    function automatic void ref_beat(input logic [7:0] m, input logic [DW-1:0] a, b, w,
                                     output logic [DW-1:0] ea, output logic [DW-1:0] eb);
        longint unsigned x, y, z, t, qq;
        qq = 64'(Q);
        for (int k = 0; k < LANES; k++) begin
            x = 64'(a[k*W +: W]);
            y = 64'(b[k*W +: W]);
            z = 64'(w[k*W +: W]);
            if (m[1]) begin
                ea[k*W +: W] = W'(x);
                eb[k*W +: W] = W'(y);
            end else if (m[0]) begin
                ea[k*W +: W] = W'((x + y) % qq);
                eb[k*W +: W] = W'((((x + qq - y) % qq) * z) % qq);
            end else begin
                t = (y * z) % qq;
                ea[k*W +: W] = W'((x + t) % qq);
                eb[k*W +: W] = W'((x + qq - t) % qq);
            end
        end
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*W +: W] = W'($urandom_range(Q - 1, 0));
        return v;
    endfunction

    // One beat through an otherwise empty pipeline with o_rdy held high.
    task automatic run_single(input string tag, input logic [7:0] m,
                              input logic [DW-1:0] a, b, w, ea, eb);
        mode  = m;
        ai    = a;
        bi    = b;
        gm    = w;
        i_vld = 1'b1;
        o_rdy = 1'b1;
        tick();
        i_vld = 1'b0;
        mode  = 8'h02;
        gm    = '1;
        ai    = '0;
        bi    = '0;
        repeat (L - 2) tick();
        check({tag, "_early"}, DW'(o_vld), DW'(1'b0));
        tick();
        check({tag, "_vld"}, DW'(o_vld), DW'(1'b1));
        check({tag, "_ao"}, ao, ea);
        check({tag, "_bo"}, bo, eb);
        tick();
    endtask

    logic [DW-1:0] ct_a, ct_b, ct_w, ct_ea, ct_eb;
    logic [DW-1:0] cur_a, cur_b, cur_w, xa, xb;
    logic [7:0]    cur_m;
    logic [L-1:0]  mv;
    logic          exp_stall, have_beat;
    exp_t          q[$];
    int            sent, got, cyc, seen;

    initial begin
        rst   = 1'b1;
        i_vld = 1'b0;
        o_rdy = 1'b1;
        mode  = 8'h00;
        ai    = '0;
        bi    = '0;
        gm    = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_o_vld", DW'(o_vld), DW'(1'b0));
        check("rst_i_rdy", DW'(i_rdy), DW'(1'b1));
        check("rst_ao", ao, '0);
        check("rst_bo", bo, '0);
        o_rdy = 1'b0;
        #1;
        check("idle_no_stall", DW'(i_rdy), DW'(1'b1));
        tick();

        // CT: lane0 basic, lane2 wrap, lane3 (Q-1)^2 = 1.
        ct_a  = {32'd0,       32'd8380416, 32'd100,     32'd5};
        ct_b  = {32'd8380416, 32'd1,       32'd200,     32'd3};
        ct_w  = {32'd8380416, 32'd1,       32'd7,       32'd2};
        ct_ea = {32'd1,       32'd0,       32'd1500,    32'd11};
        ct_eb = {32'd8380416, 32'd8380415, 32'd8379117, 32'd8380416};
        run_single("ct", 8'h00, ct_a, ct_b, ct_w, ct_ea, ct_eb);

        run_single("gs", 8'h01,
                   {32'd1000,    32'd8380416, 32'd3,       32'd5},
                   {32'd1,       32'd8380416, 32'd5,       32'd3},
                   {32'd8380416, 32'd5,       32'd2,       32'd2},
                   {32'd1001,    32'd8380415, 32'd8,       32'd8},
                   {32'd8379418, 32'd0,       32'd8380413, 32'd4});

        run_single("byp", 8'h02, '1, '1, '1, '1, '1);
        run_single("ct_rsvd", 8'hFC, ct_a, ct_b, ct_w, ct_ea, ct_eb);

        // Stream of 40 beats against a 3-low/2-high o_rdy pattern.
        mv        = '0;
        sent      = 0;
        got       = 0;
        cyc       = 0;
        have_beat = 1'b0;
        while (got < 40 && cyc < 2000) begin
            o_rdy = (cyc % 5) >= 3;
            if (sent < 40) begin
                if (!have_beat) begin
                    cur_a = rand_vec();
                    cur_b = rand_vec();
                    cur_w = rand_vec();
                    case ($urandom_range(2, 0))
                        0:       cur_m = {6'($urandom), 2'b00};
                        1:       cur_m = {6'($urandom), 2'b01};
                        default: cur_m = {6'($urandom), 2'b10};
                    endcase
                    have_beat = 1'b1;
                end
                i_vld = ($urandom_range(4, 0) != 0);
                ai    = cur_a;
                bi    = cur_b;
                gm    = cur_w;
                mode  = cur_m;
            end else begin
                i_vld = 1'b0;
                gm    = rand_vec();
                mode  = 8'($urandom);
            end
            #1;
            exp_stall = mv[L-1] && !o_rdy;
            check("strm_o_vld", DW'(o_vld), DW'(mv[L-1]));
            check("strm_i_rdy", DW'(i_rdy), DW'(!exp_stall));
            if (mv[L-1] && q.size() > 0) begin
                check("strm_ao", ao, q[0].a);
                check("strm_bo", bo, q[0].b);
                if (o_rdy) begin
                    void'(q.pop_front());
                    got++;
                end
            end
            if (i_vld && !exp_stall) begin
                ref_beat(cur_m, cur_a, cur_b, cur_w, xa, xb);
                q.push_back('{a: xa, b: xb});
                sent++;
                have_beat = 1'b0;
            end
            if (!exp_stall) mv = {mv[L-2:0], i_vld};
            tick();
            cyc++;
        end
        check("strm_count", DW'(got), DW'(40));

        // Reset with 10 beats in flight, plus one beat presented during rst.
        o_rdy = 1'b1;
        mode  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            ai    = rand_vec();
            bi    = rand_vec();
            gm    = rand_vec();
            i_vld = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        i_vld = 1'b0;
        check("mid_rst_o_vld", DW'(o_vld), DW'(1'b0));
        check("mid_rst_i_rdy", DW'(i_rdy), DW'(1'b1));
        seen = 0;
        for (int i = 0; i < L + 4; i++) begin
            if (o_vld) seen++;
            tick();
        end
        check("mid_rst_flushed", DW'(seen), DW'(0));
        run_single("post_rst", 8'h00, ct_a, ct_b, ct_w, ct_ea, ct_eb);

`ifdef BFLY_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt_rst", DW'(beat_cnt), DW'(0));
        for (int i = 0; i < 5; i++)
            run_single("cnt_beat", 8'h00, ct_a, ct_b, ct_w, ct_ea, ct_eb);
        check("cnt_five", DW'(beat_cnt), DW'(5));
        force dut.beat_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.beat_cnt;
        check("cnt_preload", DW'(beat_cnt), DW'(32'hFFFF_FFFF));
        run_single("cnt_wrap_beat", 8'h00, ct_a, ct_b, ct_w, ct_ea, ct_eb);
        check("cnt_wrap", DW'(beat_cnt), DW'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
